sm_bec_ladder: RTL

Parametrised scalar-multiplication controller for binary Edwards curve arithmetic in w-coordinates. It runs a Montgomery-ladder differential step of seven field operations per key bit over four M-bit working registers. All field multiplication is delegated to an external field-operation unit through a valid/ready request and result-valid response. It replaces the fixed-width, streamed-key controller: the key is loaded whole, the field width and key length are parameters, and the block uses an explicit start/busy/done handshake.

---
 rtl/sm_bec_ladder_pkg.sv | 25 ++
 rtl/sm_bec_ladder_sel.sv | 93 +++++++++
 rtl/sm_bec_ladder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sm_bec_ladder_pkg.sv
// rtl/sm_bec_ladder_pkg.sv - shared types and constants for the Edwards-curve ladder controller
package sm_bec_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [2:0] OP_MUL_AD = 3'd0;
   localparam logic [2:0] OP_ADD_BC = 3'd1;
   localparam logic [2:0] OP_MUL_BD = 3'd2;
   localparam logic [2:0] OP_INV_W0 = 3'd3;
   localparam logic [2:0] OP_SQR_CD = 3'd4;
   localparam logic [2:0] OP_SQR_D  = 3'd5;
   localparam logic [2:0] OP_FINAL  = 3'd6;

   localparam logic CFG_GENERAL = 1'b0;
   localparam logic CFG_CONST   = 1'b1;

   localparam int STEP_LEN = 7;

endpackage

// File: rtl/sm_bec_ladder_sel.sv
// rtl/sm_bec_ladder_sel.sv - operand selection and write-back for one ladder op
module bec_ladder_sel
   import sm_bec_pkg::*;
#(
   parameter int M = 163
) (
   input  logic [2:0]   op_i,
   input  logic         k_i,
   input  logic [M-1:0] a_i,
   input  logic [M-1:0] b_i,
   input  logic [M-1:0] c_i,
   input  logic [M-1:0] d_i,
   input  logic [M-1:0] ireg_i,
   input  logic [M-1:0] dreg_i,
   input  logic [M-1:0] res_i,
   output logic [M-1:0] op_a_o,
   output logic [M-1:0] op_b_o,
   output logic         op_cfg_o,
   output logic [3:0]   we_o,
   output logic [M-1:0] a_o,
   output logic [M-1:0] b_o,
   output logic [M-1:0] c_o,
   output logic [M-1:0] d_o
);

   logic [M-1:0] r0, r1, r2, r3;
   logic [M-1:0] n0, n1, n2, n3;
   logic [3:0]   wr;

   // The key bit only renames the working registers; the op sequence is fixed.
   always_comb begin
      if (k_i) begin
         r0 = a_i; r1 = b_i; r2 = c_i; r3 = d_i;
      end else begin
         r0 = c_i; r1 = d_i; r2 = a_i; r3 = b_i;
      end
   end

   always_comb begin
      op_a_o   = '0;
      op_b_o   = '0;
      op_cfg_o = CFG_GENERAL;
      wr       = 4'b0000;
      n0       = r0;
      n1       = r1;
      n2       = r2;
      n3       = r3;
      case (op_i)
         OP_MUL_AD: begin
            op_a_o = r0; op_b_o = r3;
            n0 = res_i; wr = 4'b0001;
         end
         OP_ADD_BC: begin
            op_a_o = r1; op_b_o = r2;
            n0 = r0 ^ res_i; wr = 4'b0001;
         end
         OP_MUL_BD: begin
            op_a_o = r1; op_b_o = r3;
            n1 = res_i; wr = 4'b0010;
         end
         OP_INV_W0: begin
            op_a_o = ireg_i; op_b_o = r0; op_cfg_o = CFG_CONST;
            n0 = r0 ^ res_i; n1 = r1 ^ res_i; wr = 4'b0011;
         end
         OP_SQR_CD: begin
            op_a_o = r2; op_b_o = r2 ^ r3;
            n2 = res_i; wr = 4'b0100;
         end
         OP_SQR_D: begin
            op_a_o = r3; op_b_o = r3;
            n3 = res_i; wr = 4'b1000;
         end
         OP_FINAL: begin
            op_a_o = dreg_i; op_b_o = r3; op_cfg_o = CFG_CONST;
            n3 = r2 ^ res_i; wr = 4'b1000;
         end
         default: begin
            wr = 4'b0000;
         end
      endcase
   end

   always_comb begin
      if (k_i) begin
         a_o = n0; b_o = n1; c_o = n2; d_o = n3;
         we_o = wr;
      end else begin
         a_o = n2; b_o = n3; c_o = n0; d_o = n1;
         we_o = {wr[1], wr[0], wr[3], wr[2]};
      end
   end

endmodule

// File: rtl/sm_bec_ladder.sv
// rtl/sm_bec_ladder.sv - Montgomery-ladder scalar multiplication controller, w-coordinates
module sm_bec_ladder
   import sm_bec_pkg::*;
#(
   parameter int M      = 163,
   parameter int N_BITS = 163,
   parameter int IW     = (N_BITS > 1) ? $clog2(N_BITS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [N_BITS-1:0] key,
   input  logic [M-1:0]      w1,
   input  logic [M-1:0]      z1,
   input  logic [M-1:0]      w2,
   input  logic [M-1:0]      z2,
   input  logic [M-1:0]      inv_w0,
   input  logic [M-1:0]      d,
   output logic              busy,
   output logic              done,
   output logic [M-1:0]      wout,
   output logic [M-1:0]      zout,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [M-1:0]      op_a,
   output logic [M-1:0]      op_b,
   output logic              op_cfg,
   input  logic              res_valid,
   input  logic [M-1:0]      res
);

   state_t            state_q, state_d;
   logic [M-1:0]      a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
   logic [M-1:0]      ireg_q, ireg_d, dreg_q, dreg_d;
   logic [N_BITS-1:0] kreg_q, kreg_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [2:0]        op_q, op_d;
   logic [M-1:0]      wout_q, wout_d, zout_q, zout_d;

   logic [M-1:0]      sel_op_a, sel_op_b;
   logic              sel_cfg;
   logic [3:0]        sel_we;
   logic [M-1:0]      sel_a, sel_b, sel_c, sel_d;

   bec_ladder_sel #(.M(M)) u_sel (
      .op_i     (op_q),
      .k_i      (kreg_q[idx_q]),
      .a_i      (a_q),
      .b_i      (b_q),
      .c_i      (c_q),
      .d_i      (d_q),
      .ireg_i   (ireg_q),
      .dreg_i   (dreg_q),
      .res_i    (res),
      .op_a_o   (sel_op_a),
      .op_b_o   (sel_op_b),
      .op_cfg_o (sel_cfg),
      .we_o     (sel_we),
      .a_o      (sel_a),
      .b_o      (sel_b),
      .c_o      (sel_c),
      .d_o      (sel_d)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      d_d     = d_q;
      ireg_d  = ireg_q;
      dreg_d  = dreg_q;
      kreg_d  = kreg_q;
      idx_d   = idx_q;
      op_d    = op_q;
      wout_d  = wout_q;
      zout_d  = zout_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            a_d     = w1;
            b_d     = z1;
            c_d     = w2;
            d_d     = z2;
            kreg_d  = key;
            ireg_d  = inv_w0;
            dreg_d  = d;
            idx_d   = IW'(N_BITS - 1);
            op_d    = OP_MUL_AD;
            state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (op_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (res_valid) begin
               if (sel_we[0]) a_d = sel_a;
               if (sel_we[1]) b_d = sel_b;
               if (sel_we[2]) c_d = sel_c;
               if (sel_we[3]) d_d = sel_d;
               if (op_q == OP_FINAL) begin
                  op_d = OP_MUL_AD;
                  if (idx_q == '0) begin
                     // Result registers load on the edge that enters DONE.
                     wout_d  = a_d;
                     zout_d  = b_d;
                     state_d = ST_DONE;
                  end else begin
                     idx_d   = idx_q - IW'(1);
                     state_d = ST_ISSUE;
                  end
               end else begin
                  op_d    = op_q + 3'd1;
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         ireg_q  <= '0;
         dreg_q  <= '0;
         kreg_q  <= '0;
         idx_q   <= '0;
         op_q    <= '0;
         wout_q  <= '0;
         zout_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         d_q     <= d_d;
         ireg_q  <= ireg_d;
         dreg_q  <= dreg_d;
         kreg_q  <= kreg_d;
         idx_q   <= idx_d;
         op_q    <= op_d;
         wout_q  <= wout_d;
         zout_q  <= zout_d;
      end
   end

   assign busy     = (state_q == ST_LOAD) || (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   assign done     = (state_q == ST_DONE);
   assign op_valid = (state_q == ST_ISSUE);
   assign op_a     = op_valid ? sel_op_a : '0;
   assign op_b     = op_valid ? sel_op_b : '0;
   assign op_cfg   = op_valid ? sel_cfg : CFG_GENERAL;
   assign wout     = wout_q;
   assign zout     = zout_q;

endmodule
